l2_request_queue: RTL and testbench

Per-core request buffer sitting directly upstream of the L2 request arbiter. It accepts L2 request packets from one core's L1/store path, holds them in a small in-order FIFO, and presents the head entry to the arbiter. The arbiter's grant (l2_ready) depends combinationally on the presented valid bit, so the presented valid depends only on flops here and never on l2_ready. One instance exists per core.

---
 rtl/l2_request_queue_pkg.sv | 35 +++
 rtl/l2_request_queue_if.sv | 44 ++++
 rtl/l2_request_queue_storage.sv | 39 +++
 rtl/l2_request_queue.sv | 134 +++++++++++++
 tb/tb_l2_request_queue.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/l2_request_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_queue_pkg
// Description : Shared defines for the L2 request path: the request packet
//               layout, the core identifier type and the system-wide request
//               queue depth.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_request_queue_pkg;

  // Identifier of the issuing core.
  typedef logic [1:0] core_id_t;

  // Kind of L2 access carried by a request.
  typedef enum logic [1:0] {
    L2_OP_READ     = 2'd0,
    L2_OP_WRITE    = 2'd1,
    L2_OP_PREFETCH = 2'd2,
    L2_OP_EVICT    = 2'd3
  } l2_opcode_e;

  // One L2 request. valid marks a live packet; all other fields are
  // carried through the queue untouched.
  typedef struct packed {
    logic        valid;
    core_id_t    core_id;
    l2_opcode_e  opcode;
    logic [31:0] addr;
  } l2req_packet_t;

  // System-wide depth of each per-core request queue.
  localparam int L2_REQ_QUEUE_DEPTH = 4;

endpackage : l2_request_queue_pkg
`default_nettype wire

// File: rtl/l2_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_queue_if
// Description : Bundle of the core-facing and arbiter-facing signals of one
//               per-core L2 request queue.
//   enqueue_request : new request from the core (.valid = push)
//   almost_full     : occupancy at or above the almost-full threshold
//   full            : queue holds DEPTH entries
//   overflow        : sticky, a push arrived while full
//   l2i_request     : head entry offered to the L2 arbiter
//   l2_ready        : arbiter accepted the head this cycle
// Modports    : master - core/arbiter side, slave - the queue itself
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_request_queue_if;
  import l2_request_queue_pkg::*;

  l2req_packet_t enqueue_request;
  logic          almost_full;
  logic          full;
  logic          overflow;
  l2req_packet_t l2i_request;
  logic          l2_ready;

  modport master (
    output enqueue_request,
    output l2_ready,
    input  almost_full,
    input  full,
    input  overflow,
    input  l2i_request
  );

  modport slave (
    input  enqueue_request,
    input  l2_ready,
    output almost_full,
    output full,
    output overflow,
    output l2i_request
  );

endinterface : l2_request_queue_if
`default_nettype wire

// File: rtl/l2_request_queue_storage.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_queue_storage
// Description : DEPTH x l2req_packet_t register array with one synchronous
//               write port and one asynchronous read port. Contents are not
//               reset; the owner qualifies the read data with its own count.
// Ports       : clk        - clock
//               write_en   - write write_data at write_addr on the rising edge
//               write_addr - entry index for the write
//               write_data - packet to store
//               read_addr  - entry index for the read
//               read_data  - packet at read_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_queue_storage
  import l2_request_queue_pkg::*;
#(
  parameter int DEPTH = L2_REQ_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  l2req_packet_t            write_data,
  input  logic [$clog2(DEPTH)-1:0] read_addr,
  output l2req_packet_t            read_data
);

  l2req_packet_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule : l2_request_queue_storage
`default_nettype wire

// File: rtl/l2_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_queue
// Description : Per-core in-order request buffer in front of the L2 request
//               arbiter. The head entry is presented with a valid bit that
//               depends only on flops, so the arbiter may derive l2_ready
//               combinationally from it.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               bus      - l2_request_queue_if.slave (enqueue_request,
//                          almost_full, full, overflow, l2i_request, l2_ready)
//               perf_stall_cycles - (L2_REQ_QUEUE_PERF_EN) saturating count
//                          of cycles with a valid head not accepted
//               perf_high_water   - (L2_REQ_QUEUE_PERF_EN) peak occupancy
// Build option: L2_REQ_QUEUE_PERF_EN adds the two performance outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_queue
  import l2_request_queue_pkg::*;
#(
  parameter int DEPTH                 = L2_REQ_QUEUE_DEPTH,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  l2_request_queue_if.slave      bus
`ifdef L2_REQ_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [$clog2(DEPTH):0] perf_high_water
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_LEVEL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL    = CNT_W'(ALMOST_FULL_THRESHOLD);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             almost_full_q;
  logic             full_q;
  logic             overflow_q;
  logic             push;
  logic             pop;
  logic             head_valid;
  l2req_packet_t    head_entry;
  l2req_packet_t    presented;

  // full_q is registered, so a push arriving while full is simply dropped
  // even if the head pops in the same cycle.
  assign head_valid = (count != '0);
  assign push       = bus.enqueue_request.valid && !full_q;
  assign pop        = head_valid && bus.l2_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      almost_full_q <= 1'b0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);   // DEPTH is a power of two: wraps naturally
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count         <= count_next;
      almost_full_q <= (count_next >= AF_LEVEL);
      full_q        <= (count_next == DEPTH_LEVEL);
      if (bus.enqueue_request.valid && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  l2_request_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk        (clk),
    .write_en   (push),
    .write_addr (tail),
    .write_data (bus.enqueue_request),
    .read_addr  (head),
    .read_data  (head_entry)
  );

  // Storage is not cleared on reset, so an empty queue presents all-zero
  // rather than whatever stale packet sits at head.
  always_comb begin
    presented = '0;
    if (head_valid) begin
      presented       = head_entry;
      presented.valid = 1'b1;
    end
  end

  assign bus.l2i_request = presented;
  assign bus.almost_full = almost_full_q;
  assign bus.full        = full_q;
  assign bus.overflow    = overflow_q;

`ifdef L2_REQ_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
      perf_high_water   <= '0;
    end else begin
      if (head_valid && !bus.l2_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (count_next > perf_high_water) begin
        perf_high_water <= count_next;
      end
    end
  end
`endif

endmodule : l2_request_queue
`default_nettype wire

// File: tb/tb_l2_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_request_queue
// Description : Self-checking bench for l2_request_queue (DEPTH=4,
//               almost-full threshold 3). Table of single-cycle vectors plus
//               hand-written reset, fill/drain, wrap and perf sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_request_queue;
  import l2_request_queue_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  l2_request_queue_if bus ();

`ifdef L2_REQ_QUEUE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [2:0]  perf_high_water;
`endif

  l2_request_queue #(
    .DEPTH                 (4),
    .ALMOST_FULL_THRESHOLD (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef L2_REQ_QUEUE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_high_water   (perf_high_water)
`endif
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDR_A = 32'h0000_1001;
  localparam logic [31:0] ADDR_B = 32'h0000_2006;
  localparam logic [31:0] ADDR_C = 32'h0000_300b;
  localparam logic [31:0] ADDR_D = 32'h0000_400c;
  localparam logic [31:0] ADDR_E = 32'h0000_500f;
  localparam logic [31:0] ADDR_F = 32'h0000_6002;
  localparam logic [31:0] ADDR_G = 32'h0000_7005;
  localparam logic [31:0] ADDR_H = 32'h0000_8009;

  typedef struct {
    logic        push;
    logic [31:0] addr;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_full;
    logic        e_af;
    logic        e_ovf;
  } vector_t;

  // Packet with fields derived from the address so every field is exercised.
  function automatic l2req_packet_t mk(input logic [31:0] addr);
    l2req_packet_t p;
    p.valid   = 1'b1;
    p.core_id = core_id_t'(addr[3:2]);
    p.opcode  = l2_opcode_e'(addr[1:0]);
    p.addr    = addr;
    return p;
  endfunction

  task automatic check_pkt(input string name, input l2req_packet_t exp);
    checks++;
    if (bus.l2i_request !== exp) begin
      failures++;
      $display("FAIL %s: l2i_request got %h expected %h", name, bus.l2i_request, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic push, input logic [31:0] addr, input logic rdy);
    l2req_packet_t p;
    p                   = mk(addr);
    p.valid             = push;
    bus.enqueue_request = p;
    bus.l2_ready        = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enqueue_request = '0;
    bus.l2_ready        = 1'b0;
  endtask

  initial begin
    vector_t       vec [13];
    logic [31:0]   model [$];
    logic [31:0]   fill [4];
    l2req_packet_t exp_pkt;

    vec[0]  = '{1'b1, ADDR_A, 1'b1, 1'b1, ADDR_A, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, ADDR_A, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b1, ADDR_B, 1'b0, 1'b1, ADDR_B, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, ADDR_C, 1'b0, 1'b1, ADDR_B, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, ADDR_D, 1'b0, 1'b1, ADDR_B, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b1, ADDR_E, 1'b0, 1'b1, ADDR_B, 1'b1, 1'b1, 1'b0};
    vec[6]  = '{1'b1, ADDR_F, 1'b1, 1'b1, ADDR_C, 1'b0, 1'b1, 1'b1};
    vec[7]  = '{1'b0, ADDR_F, 1'b1, 1'b1, ADDR_D, 1'b0, 1'b0, 1'b1};
    vec[8]  = '{1'b1, ADDR_G, 1'b1, 1'b1, ADDR_E, 1'b0, 1'b0, 1'b1};
    vec[9]  = '{1'b0, ADDR_G, 1'b1, 1'b1, ADDR_G, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b1, ADDR_H, 1'b1, 1'b1, ADDR_H, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b0, ADDR_H, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b0, ADDR_H, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};

    // Reset state
    idle_inputs();
    #1;
    check_pkt("reset_pkt", '0);
    check_bit("reset_full", bus.full, 1'b0);
    check_bit("reset_af", bus.almost_full, 1'b0);
    check_bit("reset_ovf", bus.overflow, 1'b0);
    #11 reset_n = 1'b1;

    // Table: pass-through, fill, overflow with pop, push+pop, empty ready
    for (int i = 0; i < 13; i++) begin
      step(vec[i].push, vec[i].addr, vec[i].rdy);
      exp_pkt = vec[i].e_valid ? mk(vec[i].e_addr) : '0;
      check_pkt($sformatf("vec%0d_pkt", i), exp_pkt);
      check_bit($sformatf("vec%0d_full", i), bus.full, vec[i].e_full);
      check_bit($sformatf("vec%0d_af", i), bus.almost_full, vec[i].e_af);
      check_bit($sformatf("vec%0d_ovf", i), bus.overflow, vec[i].e_ovf);
    end

    // Asynchronous reset with three entries queued and overflow set
    step(1'b1, 32'h0000_a000, 1'b0);
    step(1'b1, 32'h0000_a001, 1'b0);
    step(1'b1, 32'h0000_a002, 1'b0);
    check_bit("pre_reset_af", bus.almost_full, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_pkt("async_reset_pkt", '0);
    check_bit("async_reset_full", bus.full, 1'b0);
    check_bit("async_reset_af", bus.almost_full, 1'b0);
    check_bit("async_reset_ovf", bus.overflow, 1'b0);
    #2 reset_n = 1'b1;
    step(1'b1, ADDR_A, 1'b0);
    check_pkt("post_reset_push", mk(ADDR_A));
    step(1'b0, 32'h0, 1'b1);
    check_pkt("post_reset_drained", '0);

    // Fill to DEPTH then drain in order
    fill[0] = 32'h0000_b100; fill[1] = 32'h0000_b201;
    fill[2] = 32'h0000_b302; fill[3] = 32'h0000_b403;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill[i], 1'b0);
      check_pkt($sformatf("fill%0d_head", i), mk(fill[0]));
      check_bit($sformatf("fill%0d_af", i), bus.almost_full, (i >= 2));
      check_bit($sformatf("fill%0d_full", i), bus.full, (i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      check_pkt($sformatf("drain%0d_head", i), mk(fill[i]));
      step(1'b0, 32'h0, 1'b1);
      check_bit($sformatf("drain%0d_full", i), bus.full, 1'b0);
    end
    check_pkt("drain_empty", '0);

    // Hold count at 3 with simultaneous push+pop; pointers wrap twice
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0000_c000 + 32'(i), 1'b0);
      model.push_back(32'h0000_c000 + 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h0000_d000 + 32'(i), 1'b1);
      void'(model.pop_front());
      model.push_back(32'h0000_d000 + 32'(i));
      check_pkt($sformatf("wrap%0d_head", i), mk(model[0]));
      check_bit($sformatf("wrap%0d_af", i), bus.almost_full, 1'b1);
      check_bit($sformatf("wrap%0d_full", i), bus.full, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      check_pkt($sformatf("wrapdrain%0d_head", i), mk(model[0]));
      void'(model.pop_front());
      step(1'b0, 32'h0, 1'b1);
    end
    check_pkt("wrapdrain_empty", '0);

`ifdef L2_REQ_QUEUE_PERF_EN
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    check_word("perf_reset_stall", perf_stall_cycles, 32'd0);
    check_word("perf_reset_hw", {29'd0, perf_high_water}, 32'd0);
    #2 reset_n = 1'b1;
    step(1'b1, 32'h0000_e000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
    end
    check_word("perf_stall", perf_stall_cycles, 32'd5);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 32'h0000_e000 + 32'(i), 1'b0);
    end
    check_word("perf_high_water", {29'd0, perf_high_water}, 32'd4);
`endif

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_l2_request_queue
`default_nettype wire
